// File: rtl/types_pkg.sv
// Shared types and constants for the instruction fetch front end.
package types_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          BUF_DEPTH    = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry skid FIFO holding fetched {pc, instr} pairs.
module fetch_buffer
    import types_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  fetch_data_t i_data,
    input  logic        i_pop,
    input  logic        i_flush,
    output logic [1:0]  o_count,
    output fetch_data_t o_head
);

    fetch_data_t r_mem [2];
    logic        r_rd;
    logic        r_wr;
    logic [1:0]  r_count;
    logic        w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_count = r_count;
    assign o_head  = (r_count != 2'd0) ? r_mem[r_rd] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    // Credit logic upstream guarantees a free slot for every response.
    always_ff @(posedge clk) begin
        if (rst_n && !i_flush) begin
            assert (!(i_push && !w_pop && r_count == 2'd2));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, one-deep request tracking, credit flow control, redirect.
module fetch_unit
    import types_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    input  logic        ready_out
);

    logic [31:0] r_pc;
    logic        r_infl;
    logic [31:0] r_tag;

    logic [1:0]  w_count;
    logic [1:0]  w_occ;
    logic        w_pop;
    logic        w_acc;
    logic        w_push;
    fetch_data_t w_head;
    fetch_data_t w_wdata;

    assign w_occ     = w_count + {1'b0, r_infl};
    assign valid_out = (w_count != 2'd0) && !redirect_valid;
    assign w_pop     = valid_out && ready_out;

    // A pop frees a slot this cycle, so a full pipeline may still issue.
    assign imem_req  = reset_n && !redirect_valid &&
                       ((w_occ < 2'(BUF_DEPTH)) ||
                        (w_occ == 2'(BUF_DEPTH) && w_pop));
    assign w_acc     = imem_req && imem_gnt;
    assign imem_addr = r_pc;

    assign w_push    = r_infl && !redirect_valid;
    assign w_wdata   = '{pc: r_tag, instr: imem_rdata};
    assign instr_out = w_head.instr;
    assign pc_out    = w_head.pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc   <= RESET_PC;
            r_infl <= 1'b0;
            r_tag  <= '0;
        end else if (redirect_valid) begin
            r_pc   <= redirect_pc & ~32'h3;
            r_infl <= 1'b0;
        end else begin
            r_infl <= w_acc;
            if (w_acc) begin
                r_pc  <= r_pc + 32'd4;
                r_tag <= r_pc;
            end
        end
    end

    fetch_buffer u_buf (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_data  (w_wdata),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_count (w_count),
        .o_head  (w_head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed and random runs.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        ready_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rdata     (imem_rdata),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .valid_out      (valid_out),
        .ready_out      (ready_out)
    );

    // Memory: word at address a is ~a, returned the cycle after a grant.
    logic        mem_v;
    logic [31:0] mem_a;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_v <= 1'b0;
            mem_a <= '0;
        end else begin
            mem_v <= imem_req && imem_gnt;
            mem_a <= imem_addr;
        end
    end
    assign imem_rdata = mem_v ? ~mem_a : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        gnt;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t tv [17];

    // Scoreboard state: next PC expected at decode, next fetch address,
    // and words accepted but not yet consumed.
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    int          occ;
    int          pops;
    logic        hold_v;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        ungr_v;
    logic [31:0] ungr_addr;

    task automatic model_init();
        exp_pc    = 32'h0;
        exp_fetch = 32'h0;
        occ       = 0;
        hold_v    = 1'b0;
        ungr_v    = 1'b0;
    endtask

    task automatic step(input logic rdy, input logic gnt, input logic rv,
                        input logic [31:0] rpc);
        logic pop;
        logic acc;
        ready_out      = rdy;
        imem_gnt       = gnt;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        pop = valid_out && rdy;
        acc = imem_req && gnt;
        if (hold_v && valid_out) begin
            chk("hold_pc", pc_out, hold_pc);
            chk("hold_instr", instr_out, hold_instr);
        end
        if (ungr_v) chk("ungranted_addr", imem_addr, ungr_addr);
        if (rv) begin
            chk("redir_valid", {31'b0, valid_out}, 32'd0);
            chk("redir_req", {31'b0, imem_req}, 32'd0);
        end else if (occ < 2) begin
            chk("credit_req", {31'b0, imem_req}, 32'd1);
        end else if (!pop) begin
            chk("full_noreq", {31'b0, imem_req}, 32'd0);
        end
        if (pop) begin
            chk("out_pc", pc_out, exp_pc);
            chk("out_instr", instr_out, ~exp_pc);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (acc) begin
            chk("fetch_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
        end
        hold_v     = valid_out && !rdy;
        hold_pc    = pc_out;
        hold_instr = instr_out;
        ungr_v     = imem_req && !gnt;
        ungr_addr  = imem_addr;
        if (rv) begin
            occ       = 0;
            exp_pc    = rpc & ~32'h3;
            exp_fetch = rpc & ~32'h3;
            hold_v    = 1'b0;
        end else begin
            occ = occ + int'(acc) - int'(pop);
            chk("occupancy_le2", {31'b0, occ <= 2}, 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, valid_out}, 32'd0);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_instr"}, instr_out, 32'h0);
        chk({tag, "_pc"}, pc_out, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rdy gnt rv rpc | req addr vld pc
        tv[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h0,    1'b0, 32'h0};
        tv[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h4,    1'b0, 32'h0};
        tv[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h8,    1'b1, 32'h0};
        tv[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'hC,    1'b1, 32'h4};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h10,   1'b1, 32'h8};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h10,   1'b1, 32'h8};
        tv[6]  = '{1'b0, 1'b1, 1'b1, 32'h1002, 1'b0, 32'h10,   1'b0, 32'h0};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h1000, 1'b0, 32'h0};
        tv[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h1004, 1'b0, 32'h0};
        tv[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h1008, 1'b1, 32'h1000};
        tv[10] = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h100C, 1'b1, 32'h1004};
        tv[11] = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h100C, 1'b1, 32'h1008};
        tv[12] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h100C, 1'b0, 32'h0};
        tv[13] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h1010, 1'b0, 32'h0};
        tv[14] = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h1014, 1'b1, 32'h100C};
        tv[15] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h1014, 1'b1, 32'h100C};
        tv[16] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h1018, 1'b1, 32'h1010};

        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        ready_out      = 1'b0;
        pops           = 0;
        model_init();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");

        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ready_out      = tv[i].rdy;
            imem_gnt       = tv[i].gnt;
            redirect_valid = tv[i].rv;
            redirect_pc    = tv[i].rpc;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), {31'b0, imem_req},
                {31'b0, tv[i].req});
            chk($sformatf("vec%0d_addr", i), imem_addr, tv[i].addr);
            chk($sformatf("vec%0d_valid", i), {31'b0, valid_out},
                {31'b0, tv[i].vld});
            if (tv[i].vld) begin
                chk($sformatf("vec%0d_pc", i), pc_out, tv[i].pc);
                chk($sformatf("vec%0d_instr", i), instr_out, ~tv[i].pc);
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-stream: outputs must drop before any edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_init();

        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("bp_buffered", occ, 32'd2);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_next_pc", exp_pc, 32'h0000_0008);

        for (int i = 0; i < 800; i++) begin
            logic        rv;
            logic [31:0] rpc;
            rv  = ($urandom % 32) == 0;
            rpc = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16))
                                      : $urandom;
            step(($urandom % 4) != 0, ($urandom % 3) != 0, rv, rpc);
        end
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("progress", {31'b0, pops >= 150}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
